// File: rtl/prog_clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prog_clk_div_pkg
//  Brief    : Shared constants, types and helpers for the programmable
//             multi-channel clock divider.
//  Revision : 1.0 - initial release
// ============================================================================
package prog_clk_div_pkg;

    // Default width of divide values and per-channel counters
    localparam int c_DIV_W_DEFAULT = 16;

    // Divide value at the default width
    typedef logic [c_DIV_W_DEFAULT-1:0] div_t;

    // Width of a channel index; a single channel still gets a 1-bit index
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_channel
//  Brief    : One divider channel. Counts 0..DIV-1, drives a near-50% level
//             and a tick strobe on phase 0. A newly written divide value is
//             held pending and applied only at a period boundary, on an align
//             pulse, or immediately when the channel is off (DIV=0).
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_channel
    import prog_clk_div_pkg::*;
#(
    parameter int DIV_W       = c_DIV_W_DEFAULT,
    parameter int DEFAULT_DIV = 1024
) (
    input  logic             clk,
    input  logic             reset_fd,
    input  logic             en,
    input  logic             align,
    input  logic             wr,
    input  logic [DIV_W-1:0] div_in,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_act_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pending;
    logic             r_clk_out;
    logic             r_tick;

    logic             w_off;
    logic             w_wrap;
    logic             w_boundary;
    logic [DIV_W-1:0] w_act_next;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W:0]   w_half_next;

    // A channel with divide value 0 is parked; a wrap is the last count of an enabled period
    assign w_off      = (r_act_div == '0);
    assign w_wrap     = !w_off && en && (r_cnt == (r_act_div - DIV_W'(1)));
    assign w_boundary = align || w_off || w_wrap;

    // Divide value and count in force after this edge; high phase is ceil(DIV/2)
    always_comb begin
        w_act_next = r_act_div;
        if (w_boundary && r_pending) begin
            w_act_next = r_pend_div;
        end

        w_cnt_next = r_cnt;
        if (w_boundary) begin
            w_cnt_next = '0;
        end else if (en) begin
            w_cnt_next = r_cnt + DIV_W'(1);
        end

        w_half_next = ({1'b0, w_act_next} + (DIV_W+1)'(1)) >> 1;
    end

    // Counter, divide registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset_fd) begin
            r_cnt      <= '0;
            r_act_div  <= DIV_W'(DEFAULT_DIV);
            r_pend_div <= '0;
            r_pending  <= 1'b0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_act_div <= w_act_next;

            if (w_boundary) begin
                r_pending <= 1'b0;
            end
            // A write in a boundary cycle lands after the old value was consumed
            if (wr) begin
                r_pend_div <= div_in;
                r_pending  <= 1'b1;
            end

            r_tick <= w_wrap && !align;

            if (align) begin
                r_clk_out <= (w_act_next != '0);
            end else if (w_off) begin
                r_clk_out <= 1'b0;
            end else if (en) begin
                r_clk_out <= ({1'b0, w_cnt_next} < w_half_next);
            end
        end
    end

    assign pending = r_pending;
    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/prog_clk_divider.sv
`default_nettype none
// ============================================================================
//  Module   : prog_clk_divider
//  Brief    : Multi-channel programmable divided-clock / tick generator with
//             glitch-free ratio updates and global phase alignment.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_clk_divider
    import prog_clk_div_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DIV_W       = c_DIV_W_DEFAULT,
    parameter int DEFAULT_DIV = 1024
) (
    input  logic                      clk,
    input  logic                      reset_fd,
    input  logic [N_CH-1:0]           en,
    input  logic                      phase_align,
    input  logic                      cfg_wr,
    input  logic [ch_idx_w(N_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]          cfg_div,
    output logic [N_CH-1:0]           cfg_pending,
    output logic [N_CH-1:0]           clk_out,
    output logic [N_CH-1:0]           tick
);

    localparam int c_CH_W = ch_idx_w(N_CH);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic w_wr;

        // Out-of-range channel indices match no channel and are dropped
        assign w_wr = cfg_wr && (cfg_ch == c_CH_W'(gi));

        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .reset_fd (reset_fd),
            .en       (en[gi]),
            .align    (phase_align),
            .wr       (w_wr),
            .div_in   (cfg_div),
            .pending  (cfg_pending[gi]),
            .clk_out  (clk_out[gi]),
            .tick     (tick[gi])
        );
    end

endmodule
`default_nettype wire

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
Multi-channel programmable clock-enable/divided-clock generator. It is the parametrised successor of the fixed power-of-two divider. Each channel divides the system clock by an arbitrary run-time integer DIV, producing a near-50% divided-clock level and a one-cycle tick strobe. Ratio changes are glitch-free: they are applied only at a period boundary. A global phase-align input restarts all channels coherently. It feeds display/scan and slow-logic timing in the same clock domain.

Parameters:
N_CH, 4, number of independent divider channels (1..16)
DIV_W, 16, width of divide value and counters
DEFAULT_DIV, 1024, active divide value of every channel after reset (must be < 2**DIV_W)

Ports:
clk  in  1  system clock; all logic on posedge
reset_fd  in  1  synchronous, active-high reset
en  in  N_CH  per-channel count enable
phase_align  in  1  one-cycle pulse; restarts all channels at phase 0
cfg_wr  in  1  write strobe for divide value
cfg_ch  in  max(1,$clog2(N_CH))  target channel of cfg_wr
cfg_div  in  DIV_W  new divide value
cfg_pending  out  N_CH  channel has a written value not yet applied
clk_out  out  N_CH  divided clock level (registered)
tick  out  N_CH  one-cycle strobe per divided period (registered)

Behaviour:
- Synchronous, active-high reset on clk. reset_fd has priority over all inputs.
- Reset values: cnt=0; act_div=DEFAULT_DIV; pend_div=0; cfg_pending=0; clk_out=0; tick=0.
- Per channel, H = (act_div+1)>>1, i.e. the high phase is ceil(DIV/2).
- Enabled cycle (en[i]=1, act_div>=1):
  - If cnt==act_div-1: cnt<=0 and tick<=1. This is a wrap. If cfg_pending, act_div<=pend_div and cfg_pending<=0.
  - Otherwise: cnt<=cnt+1 and tick<=0.
  - clk_out<=(cnt_next < H_next), where H_next is computed from the divide value in force after this edge.
- Steady state: clk_out is high for cnt in [0,H-1]. tick is high exactly in the cycle where cnt==0, coincident with the clk_out rising edge. Period = DIV cycles; tick rate = f_clk/DIV.
- DIV=1: tick is high every enabled cycle and clk_out is constantly 1.
- DIV=0: channel is off. cnt is held at 0 and clk_out=0, tick=0. A pending value is applied on the next cycle regardless of en.
- en[i]=0: cnt and clk_out hold their values and tick=0. Pending values wait, except when act_div==0.
- cfg_wr: pend_div[cfg_ch]<=cfg_div and cfg_pending[cfg_ch]<=1.
  - Rewriting before the apply overwrites the value; last write wins.
  - cfg_ch>=N_CH: the write is ignored.
  - Write in the same cycle as a wrap on that channel: the wrap applies the old pending value (if any); the new value is stored and stays pending.
- phase_align=1 (reset_fd low): every channel sets cnt<=0. Pending values are applied now. clk_out<=(new act_div>=1), tick<=0.
  - Takes priority over count/wrap in that cycle, but a same-cycle cfg_wr is still stored as pending.
- Counter width is DIV_W. cnt never exceeds act_div-1, so there is no overflow path.
- Reset mid-period truncates that period immediately. There is no partial-period output afterwards.

Decomposition:
- Package prog_clk_div_pkg holds: DIV_W default, the channel-index width function, and a typedef div_t = logic [DIV_W-1:0].
- Sub-module clk_div_channel: one counter, act/pend registers, clk_out/tick. Ports: clk, reset_fd, en, align, wr, div_in, pending, clk_out, tick.
- Top level: generate loop over N_CH, plus cfg_ch decode.

Test Plan:
- Reset, then en=all 1, DEFAULT_DIV=1024 -> tick[0] every 1024 cycles; clk_out[0] high 512 cycles and low 512 cycles.
- cfg_wr ch1 div=5 mid-period -> cfg_pending[1]=1 until ch1's next wrap. Then period=5, high 3 / low 2, tick aligned with the rising edge.
- Set ch2 div=1, then div=0 -> tick[2]=1 every cycle and clk_out[2]=1; then after the wrap clk_out[2]=0 and tick[2]=0; a later write of div=4 applies next cycle (pending clears).
- Set ch0=6, ch3=9, then pulse phase_align -> both show tick 0 the next cycle and cnt=0. Rising edges coincide at cycle 0 and every 18 cycles.
- cfg_wr ch0 div=3 in the exact wrap cycle while pending div=8 -> 8 is applied, 3 stays pending, and 3 is applied after one 8-cycle period.
- en[0] deasserted for 10 cycles mid-high phase -> clk_out[0] frozen high and no tick; the period resumes with the remaining count. reset_fd mid-period -> all outputs 0 next cycle and act_div=1024.
